// File: rtl/montador_instrucao_if.sv
// Instruction handshake bundle between the encoder and the instruction register.
// The encoder drives the word and its valid flag; the consumer drives ready.
interface montador_instrucao_if;
  logic [31:0] instrucao;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instrucao,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instrucao,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/montador_instrucao.sv
// montador_instrucao: builds {op, fonte, destino, imm} instruction words from
// keypad strobes and presents them over a valid/ready handshake.
// Optional backspace key enabled by defining MONTADOR_APAGA_EN.
module montador_instrucao #(
  parameter int         IMM_W       = 25,
  parameter logic [2:0] OP_INVALIDO = 3'b101
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic [3:0]                i_digito,
  input  logic                      i_digito_valid,
  input  logic [2:0]                i_op,
  input  logic                      i_op_valid,
  input  logic [1:0]                i_fonte,
  input  logic [1:0]                i_destino,
  input  logic                      i_apaga,
  input  logic                      i_enter,
  output logic                      o_ocupado,
  output logic                      o_overflow,
  output logic                      o_erro,
  output logic [IMM_W-1:0]          o_imediato_atual,
  montador_instrucao_if.master      m_instr
);

  localparam int              MUL_W   = IMM_W + 5;
  localparam logic [IMM_W-1:0] MAX_IMM = {IMM_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IMM_W-1:0]   r_acc;
  logic [IMM_W-1:0]   w_acc_next;
  logic [2:0]         r_opcode;
  logic [2:0]         w_opcode_next;
  logic               r_overflow;
  logic               w_overflow_next;
  logic               r_erro;
  logic               w_erro_next;
  logic [31:0]        r_instrucao;
  logic [31:0]        w_instrucao_next;
  logic [MUL_W-1:0]   w_acc_mul;

`ifndef MONTADOR_APAGA_EN
  // Backspace key is not part of this build; keep the port for a fixed pinout.
  logic w_unused_apaga;
  assign w_unused_apaga = i_apaga;
`endif

  // Decimal shift-in of the new digit, wide enough that it cannot wrap.
  assign w_acc_mul = ({{(MUL_W-IMM_W){1'b0}}, r_acc} * MUL_W'(10))
                   + {{(MUL_W-4){1'b0}}, i_digito};

  // State and datapath registers; reset clears everything, dropping any pending word.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_opcode    <= 3'b000;
      r_overflow  <= 1'b0;
      r_erro      <= 1'b0;
      r_instrucao <= '0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_opcode    <= w_opcode_next;
      r_overflow  <= w_overflow_next;
      r_erro      <= w_erro_next;
      r_instrucao <= w_instrucao_next;
    end
  end

  // Next-state and datapath update: key handling while editing, hold while presenting.
  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_opcode_next    = r_opcode;
    w_overflow_next  = r_overflow;
    w_erro_next      = 1'b0;
    w_instrucao_next = r_instrucao;

    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (i_enter) begin
          // Other strobes in the enter cycle are dropped without an error.
          w_instrucao_next = {r_opcode, i_fonte, i_destino, r_acc};
          w_state_next     = S_OUT;
        end else begin
          if (i_digito_valid) begin
            if (i_digito > 4'd9) begin
              w_erro_next = 1'b1;
            end else begin
              if (w_acc_mul > {{(MUL_W-IMM_W){1'b0}}, MAX_IMM}) begin
                w_acc_next      = MAX_IMM;
                w_overflow_next = 1'b1;
              end else begin
                w_acc_next = w_acc_mul[IMM_W-1:0];
              end
              w_state_next = S_ACCUM;
            end
          end
`ifdef MONTADOR_APAGA_EN
          // A digit takes precedence over backspace in the same cycle.
          else if (i_apaga) begin
            w_acc_next      = r_acc / IMM_W'(10);
            w_overflow_next = 1'b0;
          end
`endif
          if (i_op_valid) begin
            if (i_op == OP_INVALIDO) begin
              w_erro_next = 1'b1;
            end else begin
              w_opcode_next = i_op;
              w_state_next  = S_ACCUM;
            end
          end
        end
      end

      S_OUT: begin
        if (m_instr.instr_ready) begin
          w_state_next     = S_IDLE;
          w_acc_next       = '0;
          w_opcode_next    = 3'b000;
          w_overflow_next  = 1'b0;
          w_instrucao_next = '0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign m_instr.instrucao   = r_instrucao;
  assign m_instr.instr_valid = (r_state == S_OUT);
  assign o_ocupado           = (r_state == S_OUT);
  assign o_overflow          = r_overflow;
  assign o_erro              = r_erro;
  assign o_imediato_atual    = r_acc;

endmodule

// File: tb/tb_montador_instrucao.sv
// Testbench for montador_instrucao: scoreboard of expected instruction words,
// pushed on enter and popped on each handshake transfer.
module tb_montador_instrucao;

  localparam logic [24:0] MAX_IMM = 25'h1FFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digito;
  logic        digito_valid;
  logic [2:0]  op;
  logic        op_valid;
  logic [1:0]  fonte;
  logic [1:0]  destino;
  logic        apaga;
  logic        enter;
  logic        ocupado;
  logic        overflow;
  logic        erro;
  logic [24:0] imediato;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] sb_q[$];
  logic [24:0] m_acc;
  logic [2:0]  m_op;
  logic        m_ovf;

  montador_instrucao_if u_if ();

  always #5 clk = ~clk;

  montador_instrucao dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_digito         (digito),
    .i_digito_valid   (digito_valid),
    .i_op             (op),
    .i_op_valid       (op_valid),
    .i_fonte          (fonte),
    .i_destino        (destino),
    .i_apaga          (apaga),
    .i_enter          (enter),
    .o_ocupado        (ocupado),
    .o_overflow       (overflow),
    .o_erro           (erro),
    .o_imediato_atual (imediato),
    .m_instr          (u_if)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_op  = 3'b000;
    m_ovf = 1'b0;
  endtask

  task automatic press_digit(input logic [3:0] d);
    longint v;
    digito = d; digito_valid = 1'b1;
    tick();
    digito_valid = 1'b0;
    if (d > 4'd9) begin
      check_val("digit_erro", 32'(erro), 32'd1);
    end else begin
      v = longint'(m_acc) * 10 + longint'(d);
      if (v > longint'(MAX_IMM)) begin
        m_acc = MAX_IMM;
        m_ovf = 1'b1;
      end else begin
        m_acc = v[24:0];
      end
      check_val("digit_noerro", 32'(erro), 32'd0);
    end
    check_val("digit_acc", 32'(imediato), 32'(m_acc));
    check_val("digit_ovf", 32'(overflow), 32'(m_ovf));
    $display("digit %0d -> acc %0d ovf %0b", d, imediato, overflow);
  endtask

  task automatic press_op(input logic [2:0] o);
    op = o; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    if (o == 3'b101) begin
      check_val("op_erro", 32'(erro), 32'd1);
      tick();
      check_val("op_erro_pulse", 32'(erro), 32'd0);
    end else begin
      m_op = o;
      check_val("op_noerro", 32'(erro), 32'd0);
    end
    $display("op %03b -> erro %0b", o, erro);
  endtask

  task automatic press_apaga();
    apaga = 1'b1;
    tick();
    apaga = 1'b0;
`ifdef MONTADOR_APAGA_EN
    m_acc = m_acc / 25'd10;
    m_ovf = 1'b0;
`endif
    check_val("apaga_acc", 32'(imediato), 32'(m_acc));
    check_val("apaga_erro", 32'(erro), 32'd0);
    $display("apaga -> acc %0d", imediato);
  endtask

  task automatic press_enter(input logic [1:0] f, input logic [1:0] d);
    fonte = f; destino = d; enter = 1'b1;
    sb_q.push_back({m_op, f, d, m_acc});
    tick();
    enter = 1'b0;
    check_val("enter_valid", 32'(u_if.instr_valid), 32'd1);
    check_val("enter_ocupado", 32'(ocupado), 32'd1);
    $display("enter f=%0d d=%0d -> valid %0b", f, d, u_if.instr_valid);
  endtask

  task automatic consume();
    int n;
    logic [31:0] exp;
    n = 0;
    while (!u_if.instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!u_if.instr_valid) begin
      check_val("wait_valid", 32'd0, 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd0, 32'd1);
      return;
    end
    exp = sb_q.pop_front();
    check_val("instrucao", u_if.instrucao, exp);
    $display("transfer instrucao 0x%08h (expected 0x%08h)", u_if.instrucao, exp);
    u_if.instr_ready = 1'b1;
    tick();
    u_if.instr_ready = 1'b0;
    model_clear();
    check_val("post_valid", 32'(u_if.instr_valid), 32'd0);
    check_val("post_ocupado", 32'(ocupado), 32'd0);
    check_val("post_acc", 32'(imediato), 32'd0);
    check_val("post_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    digito = '0; digito_valid = 1'b0; op = '0; op_valid = 1'b0;
    fonte = '0; destino = '0; apaga = 1'b0; enter = 1'b0;
    u_if.instr_ready = 1'b0;
    model_clear();

    // Reset held with random strobes
    for (int i = 0; i < 6; i++) begin
      digito = 4'($urandom_range(0, 15)); digito_valid = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7)); op_valid = 1'($urandom_range(0, 1));
      enter = 1'($urandom_range(0, 1)); apaga = 1'($urandom_range(0, 1));
      u_if.instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_val("rst_valid", 32'(u_if.instr_valid), 32'd0);
    check_val("rst_instr", u_if.instrucao, 32'd0);
    check_val("rst_ocupado", 32'(ocupado), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_erro", 32'(erro), 32'd0);
    check_val("rst_acc", 32'(imediato), 32'd0);
    $display("reset held -> valid %0b acc %0d", u_if.instr_valid, imediato);
    digito_valid = 1'b0; op_valid = 1'b0; enter = 1'b0; apaga = 1'b0;
    u_if.instr_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    // Empty enter gives an all-zero word
    press_enter(2'd0, 2'd0);
    consume();

    // 123, sub, fonte 2, destino 1 -> 0x3200007B
    press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
    press_op(3'b001);
    press_enter(2'd2, 2'd1);
    consume();

    // Saturation with nine 9s
    for (int i = 0; i < 9; i++) press_digit(4'd9);
    press_op(3'b000);
    press_enter(2'd0, 2'd0);
    consume();

    // Rejected keys, then mem read of 5
    press_op(3'b101);
    press_digit(4'd12);
    tick();
    check_val("erro_clear", 32'(erro), 32'd0);
    press_op(3'b110);
    press_digit(4'd5);
    press_enter(2'd3, 2'd0);
    consume();

    // Backpressure: keys ignored while presenting
    press_digit(4'd7);
    press_enter(2'd1, 2'd3);
    for (int i = 0; i < 5; i++) begin
      digito = 4'($urandom_range(0, 15)); digito_valid = 1'b1;
      op = 3'($urandom_range(0, 7)); op_valid = 1'b1;
      apaga = 1'b1; enter = 1'b1;
      tick();
      check_val("bp_instr", u_if.instrucao, sb_q[0]);
      check_val("bp_acc", 32'(imediato), 32'(m_acc));
      check_val("bp_ocupado", 32'(ocupado), 32'd1);
      check_val("bp_erro", 32'(erro), 32'd0);
      $display("backpressure cycle %0d -> instrucao 0x%08h", i, u_if.instrucao);
    end
    digito_valid = 1'b0; op_valid = 1'b0; apaga = 1'b0; enter = 1'b0;
    consume();

    // Digit and op in the same cycle
    digito = 4'd8; digito_valid = 1'b1; op = 3'b011; op_valid = 1'b1;
    tick();
    digito_valid = 1'b0; op_valid = 1'b0;
    m_acc = 25'd8; m_op = 3'b011;
    check_val("both_acc", 32'(imediato), 32'(m_acc));
    press_enter(2'd1, 2'd1);
    consume();

    // Backspace (behaviour depends on build)
    press_apaga();
    press_digit(4'd4); press_digit(4'd5); press_digit(4'd6);
    press_apaga();
    press_enter(2'd0, 2'd2);
    consume();

    // Asynchronous reset while presenting
    press_digit(4'd3);
    press_enter(2'd0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", 32'(u_if.instr_valid), 32'd0);
    check_val("async_rst_acc", 32'(imediato), 32'd0);
    $display("reset in S_OUT -> valid %0b", u_if.instr_valid);
    void'(sb_q.pop_front());
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
